dmem_lane_ctrl: RTL

- Parametrised byte-lane data memory with a load/store front end for the xgriscv core.
- Decodes RISC-V load/store funct3 and generates byte-lane enables internally.
- Sign- or zero-extends load data, rejects misaligned or out-of-range accesses, and optionally zero-clears the array after reset.
- Sits between the MEM stage and on-chip data RAM. Takes one request per cycle through a valid/ready handshake and returns a registered response exactly one cycle later.

---
 rtl/dmem_lane_ctrl_if.sv | 25 ++
 rtl/dmem_lane_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dmem_lane_ctrl_if.sv
// Request/response bus between the MEM stage and the byte-lane data memory.
// One request per cycle under valid/ready; the response follows one cycle later.
interface dmem_lane_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_lane_ctrl.sv
// Byte-lane data memory with RISC-V load/store decode, lane steering, load
// extension, fault detection and an optional zero-clear sweep after reset.
module dmem_lane_ctrl #(
    parameter int XLEN           = 32,
    parameter int DEPTH          = 128,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rstn,
    dmem_lane_ctrl_if.slave   bus,
    output logic              busy
);
    localparam int LANES = XLEN / 8;
    localparam int OFFW  = $clog2(LANES);
    localparam int AW    = $clog2(DEPTH);
    localparam int ABITS = AW + OFFW;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   cnt;
    logic            ready_q;
    logic [XLEN-1:0] mem [DEPTH];

    logic [AW-1:0]    idx_p0;
    logic [OFFW-1:0]  off_p0;
    logic [2:0]       off3_p0;
    logic [1:0]       size_p0;
    logic             align_ok_p0, range_ok_p0, err_p0, acc_p0, wr_p0;
    logic [LANES-1:0] lane_p0;
    logic [XLEN-1:0]  wdata_p0;

    logic [XLEN-1:0]  rd_word_p1;
    logic [OFFW-1:0]  off_p1;
    logic [2:0]       f3_p1;
    logic             vld_p1, err_p1, ld_p1;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                   ((XLEN == 64) && (f3 == 3'b011));
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101) ||
               ((XLEN == 64) && ((f3 == 3'b011) || (f3 == 3'b110)));
    endfunction

    function automatic logic [LANES-1:0] lane_mask(input logic [1:0] size, input logic [2:0] off3);
        logic [15:0] m;
        m = ((16'd1 << (5'd1 << size)) - 16'd1) << off3;
        return m[LANES-1:0];
    endfunction

    // Aligned bytes arrive in the low bits; pick sign or zero extension by funct3.
    function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] raw, input logic [2:0] f3);
        logic signed [7:0]      b;
        logic signed [15:0]     h;
        logic signed [31:0]     w;
        logic signed [XLEN-1:0] s;
        b = raw[7:0];
        h = raw[15:0];
        w = raw[31:0];
        case (f3)
            3'b000:  s = XLEN'(b);
            3'b001:  s = XLEN'(h);
            3'b010:  s = XLEN'(w);
            3'b100:  s = XLEN'(raw[7:0]);
            3'b101:  s = XLEN'(raw[15:0]);
            3'b110:  s = XLEN'(raw[31:0]);
            default: s = raw;
        endcase
        return s;
    endfunction

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            ST_CLEAR: begin
                busy = 1'b1;
                if (cnt == AW'(DEPTH - 1))
                    state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            cnt     <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == ST_RUN);
            if (state == ST_CLEAR)
                cnt <= cnt + 1'b1;
        end
    end

    // p0: request decode, fault detection and store lane steering
    always_comb begin
        idx_p0      = bus.req_addr[ABITS-1:OFFW];
        off_p0      = bus.req_addr[OFFW-1:0];
        off3_p0     = 3'(off_p0);
        size_p0     = bus.req_funct3[1:0];
        range_ok_p0 = ((bus.req_addr >> ABITS) == '0);
        case (size_p0)
            2'd0:    align_ok_p0 = 1'b1;
            2'd1:    align_ok_p0 = ~off3_p0[0];
            2'd2:    align_ok_p0 = (off3_p0[1:0] == 2'b00);
            default: align_ok_p0 = (off3_p0 == 3'b000);
        endcase
        err_p0   = ~(range_ok_p0 & align_ok_p0 & f3_legal(bus.req_we, bus.req_funct3));
        acc_p0   = bus.req_valid & ready_q;
        wr_p0    = acc_p0 & bus.req_we & ~err_p0;
        lane_p0  = lane_mask(size_p0, off3_p0);
        wdata_p0 = bus.req_wdata << {off_p0, 3'b000};
    end

    // The clear sweep owns the write port; requests cannot be accepted meanwhile.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR)
            mem[cnt] <= '0;
        else if (wr_p0)
            for (int l = 0; l < LANES; l++)
                if (lane_p0[l])
                    mem[idx_p0][8*l +: 8] <= wdata_p0[8*l +: 8];
        if (acc_p0) begin
            rd_word_p1 <= mem[idx_p0];
            off_p1     <= off_p0;
            f3_p1      <= bus.req_funct3;
        end
    end

    // p1: registered response
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
            ld_p1  <= 1'b0;
        end else begin
            vld_p1 <= acc_p0;
            err_p1 <= acc_p0 & err_p0;
            ld_p1  <= acc_p0 & ~bus.req_we & ~err_p0;
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = vld_p1;
    assign bus.resp_err   = err_p1;
    assign bus.resp_rdata = ld_p1 ? load_ext(rd_word_p1 >> {off_p1, 3'b000}, f3_p1) : '0;
endmodule
